// File: rtl/byte_striping_pair_if.sv
// Word-stream and lane bundle for byte_striping_pair.
// STRIPE_PARITY_EN adds the parity_0/parity_1 lane parity signals.
interface byte_striping_pair_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic [DATA_W-1:0] lane0;
    logic [DATA_W-1:0] lane1;
    logic              valid_0;
    logic              valid_1;
    logic              phase_f;
    logic [CNT_W-1:0]  pair_count;
`ifdef STRIPE_PARITY_EN
    logic              parity_0;
    logic              parity_1;

    // master: word source / lane consumer; slave: the striping block
    modport master (output data_in, valid_in,
                    input  lane0, lane1, valid_0, valid_1, phase_f, pair_count, parity_0, parity_1);
    modport slave  (input  data_in, valid_in,
                    output lane0, lane1, valid_0, valid_1, phase_f, pair_count, parity_0, parity_1);
`else
    modport master (output data_in, valid_in,
                    input  lane0, lane1, valid_0, valid_1, phase_f, pair_count);
    modport slave  (input  data_in, valid_in,
                    output lane0, lane1, valid_0, valid_1, phase_f, pair_count);
`endif
endinterface

// File: rtl/byte_striping_pair.sv
// Splits a full-rate word stream into even/odd lanes launched as aligned pairs at half rate.
// STRIPE_PARITY_EN adds per-lane XOR parity registered with each launch.
module byte_striping_pair #(
    parameter int DATA_W       = 32,
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic                 clk_2f,
    input  logic                 reset,
    byte_striping_pair_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, HALF = 1'b1} state_t;

    localparam logic [7:0] IDLE_LAST = 8'(FLUSH_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] slot0_reg, slot0_next;
    logic [7:0]        idle_cnt_reg, idle_cnt_next;

    logic [DATA_W-1:0] pend0_reg, pend1_reg;
    logic [DATA_W-1:0] pend0_next, pend1_next;
    logic              pend_v1_reg, pend_v1_next;
    logic              pend_full_reg;
    logic              pend_load;

    logic [DATA_W-1:0] lane0_reg, lane1_reg;
    logic              valid_0_reg, valid_1_reg;
    logic              phase_reg;
    logic [CNT_W-1:0]  count_reg;
`ifdef STRIPE_PARITY_EN
    logic              parity_0_reg, parity_1_reg;
`endif

    // State register: collector, pending pair and launch stage
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_reg     <= IDLE;
            slot0_reg     <= '0;
            idle_cnt_reg  <= '0;
            pend0_reg     <= '0;
            pend1_reg     <= '0;
            pend_v1_reg   <= 1'b0;
            pend_full_reg <= 1'b0;
            lane0_reg     <= '0;
            lane1_reg     <= '0;
            valid_0_reg   <= 1'b0;
            valid_1_reg   <= 1'b0;
            phase_reg     <= 1'b0;
            count_reg     <= '0;
`ifdef STRIPE_PARITY_EN
            parity_0_reg  <= 1'b0;
            parity_1_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            slot0_reg    <= slot0_next;
            idle_cnt_reg <= idle_cnt_next;
            phase_reg    <= ~phase_reg;
            if (pend_load) begin
                pend0_reg   <= pend0_next;
                pend1_reg   <= pend1_next;
                pend_v1_reg <= pend_v1_next;
            end
            // A refill on a launch edge keeps the buffer full; launch consumes the old pair
            pend_full_reg <= pend_load | (pend_full_reg & ~phase_reg);
            if (phase_reg) begin
                if (pend_full_reg) begin
                    lane0_reg    <= pend0_reg;
                    lane1_reg    <= pend1_reg;
                    valid_0_reg  <= 1'b1;
                    valid_1_reg  <= pend_v1_reg;
                    count_reg    <= count_reg + 1'b1;
`ifdef STRIPE_PARITY_EN
                    parity_0_reg <= ^pend0_reg;
                    parity_1_reg <= ^pend1_reg;
`endif
                end else begin
                    valid_0_reg <= 1'b0;
                    valid_1_reg <= 1'b0;
                end
            end
        end
    end

    // Next-state: pair up words, or flush a lone word after the idle timeout
    always_comb begin
        state_next    = state_reg;
        slot0_next    = slot0_reg;
        idle_cnt_next = idle_cnt_reg;
        pend_load     = 1'b0;
        pend0_next    = slot0_reg;
        pend1_next    = '0;
        pend_v1_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.valid_in) begin
                    slot0_next    = bus.data_in;
                    idle_cnt_next = '0;
                    state_next    = HALF;
                end
            end
            HALF: begin
                if (bus.valid_in) begin
                    pend_load    = 1'b1;
                    pend1_next   = bus.data_in;
                    pend_v1_next = 1'b1;
                    state_next   = IDLE;
                end else if (idle_cnt_reg == IDLE_LAST) begin
                    pend_load  = 1'b1;
                    state_next = IDLE;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs come straight from registers
    always_comb begin
        bus.lane0      = lane0_reg;
        bus.lane1      = lane1_reg;
        bus.valid_0    = valid_0_reg;
        bus.valid_1    = valid_1_reg;
        bus.phase_f    = phase_reg;
        bus.pair_count = count_reg;
`ifdef STRIPE_PARITY_EN
        bus.parity_0   = parity_0_reg;
        bus.parity_1   = parity_1_reg;
`endif
    end
endmodule

// File: tb/tb_byte_striping_pair.sv
// Randomized bench for byte_striping_pair against a queue-based reference model.
// Define STRIPE_PARITY_EN to also check the lane parity outputs.
module tb_byte_striping_pair;
    localparam int DATA_W       = 32;
    localparam int FLUSH_CYCLES = 4;
    localparam int CNT_W        = 8;

    logic clk_2f = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_2f = ~clk_2f;

    byte_striping_pair_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    byte_striping_pair #(.DATA_W(DATA_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    typedef struct packed {
        logic [DATA_W-1:0] w0;
        logic [DATA_W-1:0] w1;
        logic              v1;
    } pair_t;

    int checks   = 0;
    int failures = 0;
    int ovf_events = 0;

    // Reference model state
    pair_t             ready_q[$];
    logic [DATA_W-1:0] m_part;
    bit                m_have_part;
    int                m_idle;
    logic [DATA_W-1:0] m_lane0, m_lane1;
    logic              m_v0, m_v1, m_phase, m_par0, m_par1;
    logic [CNT_W-1:0]  m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_clear();
        ready_q.delete();
        m_have_part = 0; m_part = '0; m_idle = 0;
        m_lane0 = '0; m_lane1 = '0; m_v0 = 0; m_v1 = 0;
        m_phase = 0; m_cnt = '0; m_par0 = 0; m_par1 = 0;
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [DATA_W-1:0] d);
        pair_t p;
        if (r) begin
            model_clear();
            return;
        end
        if (m_phase) begin
            if (ready_q.size() > 0) begin
                p = ready_q.pop_front();
                m_lane0 = p.w0; m_lane1 = p.w1; m_v0 = 1; m_v1 = p.v1;
                m_par0 = ^p.w0; m_par1 = ^p.w1;
                m_cnt = m_cnt + 1'b1;
            end else begin
                m_v0 = 0; m_v1 = 0;
            end
        end
        if (v) begin
            if (m_have_part) begin
                ready_q.push_back('{w0: m_part, w1: d, v1: 1'b1});
                m_have_part = 0;
            end else begin
                m_part = d; m_have_part = 1; m_idle = 0;
            end
        end else if (m_have_part) begin
            m_idle++;
            if (m_idle == FLUSH_CYCLES) begin
                ready_q.push_back('{w0: m_part, w1: '0, v1: 1'b0});
                m_have_part = 0;
            end
        end
        m_phase = ~m_phase;
    endtask

    task automatic compare();
        check_eq("lane0", 64'(bus.lane0), 64'(m_lane0));
        check_eq("lane1", 64'(bus.lane1), 64'(m_lane1));
        check_eq("valid_0", 64'(bus.valid_0), 64'(m_v0));
        check_eq("valid_1", 64'(bus.valid_1), 64'(m_v1));
        check_eq("phase_f", 64'(bus.phase_f), 64'(m_phase));
        check_eq("pair_count", 64'(bus.pair_count), 64'(m_cnt));
`ifdef STRIPE_PARITY_EN
        check_eq("parity_0", 64'(bus.parity_0), 64'(m_par0));
        check_eq("parity_1", 64'(bus.parity_1), 64'(m_par1));
`endif
    endtask

    // One clock cycle: drive, let the edge happen, advance model, check on falling edge
    task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] d);
        reset = r; bus.valid_in = v; bus.data_in = d;
        @(posedge clk_2f);
        model_edge(r, v, d);
        @(negedge clk_2f);
        compare();
    endtask

    // The pending buffer must never be loaded while full and not launching
    always @(negedge clk_2f) begin
        if (!reset && dut.pend_full_reg && dut.pend_load && !dut.phase_reg)
            ovf_events++;
    end

    initial begin
        logic [DATA_W-1:0] w;
        int density;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        model_clear();
        @(negedge clk_2f);

        // Reset 3 cycles then idle
        repeat (3) step(1, 0, '0);
        repeat (6) step(0, 0, '0);

        // Single pair
        step(1, 0, '0);
        step(0, 1, 32'hAAAA0001);
        step(0, 1, 32'hBBBB0002);
        repeat (6) step(0, 0, '0);

        // Continuous stream 1..8
        step(1, 0, '0);
        for (int i = 1; i <= 8; i++) step(0, 1, DATA_W'(i));
        repeat (6) step(0, 0, '0);

        // Lone word flushed after idle timeout
        step(1, 0, '0);
        step(0, 1, 32'hDEADBEEF);
        repeat (8) step(0, 0, '0);

        // Reset while HALF with a full pending pair
        step(1, 0, '0);
        step(0, 1, 32'h0000_0101);
        step(0, 1, 32'h0000_0202);
        step(0, 1, 32'h0000_0303);
        step(1, 0, '0);
        step(0, 1, 32'h11);
        step(0, 1, 32'h22);
        repeat (6) step(0, 0, '0);

        // 256 pairs wrap pair_count; first pair has lane0=7
        step(1, 0, '0);
        step(0, 1, 32'h7);
        step(0, 1, 32'h3);
        for (int i = 0; i < 510; i++) step(0, 1, $urandom);
        repeat (6) step(0, 0, '0);

        // Random traffic with varying density and occasional reset
        for (int blk = 0; blk < 20; blk++) begin
            density = $urandom_range(10, 100);
            for (int i = 0; i < 100; i++) begin
                w = $urandom;
                step(($urandom_range(0, 299) == 0), ($urandom_range(1, 100) <= density), w);
            end
            repeat ($urandom_range(0, 8)) step(0, 0, '0);
        end

        check_eq("pend_overflow", 64'(ovf_events), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
